// File: rtl/jtag_host.sv
// jtag_host: JTAG initiator that walks the TAP through whole reset / IR / DR scans from a command port.
// TCK runs at CLK_DIV system clocks per half-period; TMS/TDI change only at the start of each low half.
module jtag_host #(
  parameter int CLK_DIV = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [3:0]  cmd_len,
  input  logic [15:0] cmd_data,
  output logic        rsp_done,
  output logic [15:0] rsp_data,
  output logic        host_tck,
  output logic        host_tms,
  output logic        host_tdi,
  input  logic        host_tdo
);
  localparam logic [1:0] OP_RESET = 2'b00;
  localparam logic [1:0] OP_IR    = 2'b01;
  localparam logic [1:0] OP_DR    = 2'b10;
  localparam logic [1:0] OP_RSVD  = 2'b11;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, stateNext;

  logic [1:0]  op;
  logic [4:0]  len;
  logic [15:0] data;
  logic [7:0]  divCnt;
  logic        highHalf;
  logic [4:0]  tick;
  logic [4:0]  numTicks, pre;
  logic [3:0]  shiftIdx;
  logic        isShift, lastCnt, lastTick;
  logic [1:0]  firstBits, nextBits;

  // {tms, tdi} for tick k of a scan of l bits; the TAP is assumed to start in Run-Test/Idle.
  function automatic logic [1:0] tickBits(input logic [1:0] o, input logic [4:0] l,
                                          input logic [4:0] k, input logic [15:0] d);
    logic [4:0] p;
    logic [3:0] s;
    logic       tms, tdi;
    p   = (o == OP_IR) ? 5'd4 : 5'd3;
    s   = 4'(k - p);
    tms = 1'b0;
    tdi = 1'b0;
    if (o == OP_RESET) tms = (k < 5'd5);
    else if (k < p) tms = (k == 5'd0) || (k == 5'd1 && o == OP_IR);
    else if (k < p + l) begin
      tms = (s == 4'(l - 5'd1));
      tdi = d[s];
    end else tms = (k == p + l);
    return {tms, tdi};
  endfunction

  always_comb begin
    pre      = (op == OP_IR) ? 5'd4 : 5'd3;
    shiftIdx = 4'(tick - pre);
    isShift  = (op == OP_IR || op == OP_DR) && (tick >= pre) && (tick < pre + len);
    case (op)
      OP_RESET: numTicks = 5'd6;
      OP_IR:    numTicks = len + 5'd6;
      OP_DR:    numTicks = len + 5'd5;
      default:  numTicks = 5'd0;
    endcase
    lastCnt   = (divCnt == 8'(CLK_DIV - 1));
    lastTick  = (tick == numTicks - 5'd1);
    firstBits = tickBits(cmd_op, {1'b0, cmd_len} + 5'd1, 5'd0, cmd_data);
    nextBits  = tickBits(op, len, tick + 5'd1, data);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    cmd_ready = 1'b0;
    rsp_done  = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) stateNext = RUN;
      end
      RUN:  if (numTicks == 5'd0 || (lastCnt && highHalf && lastTick)) stateNext = DONE;
      DONE: begin
        rsp_done  = 1'b1;
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op       <= '0;
      len      <= '0;
      data     <= '0;
      divCnt   <= '0;
      highHalf <= 1'b0;
      tick     <= '0;
      rsp_data <= '0;
      host_tck <= 1'b0;
      host_tms <= 1'b1;
      host_tdi <= 1'b0;
    end else if (state == IDLE) begin
      if (cmd_valid) begin
        op       <= cmd_op;
        len      <= {1'b0, cmd_len} + 5'd1;
        data     <= cmd_data;
        divCnt   <= '0;
        highHalf <= 1'b0;
        tick     <= '0;
        rsp_data <= '0;
        if (cmd_op != OP_RSVD) {host_tms, host_tdi} <= firstBits;
      end
    end else if (state == RUN && numTicks != 5'd0) begin
      if (!lastCnt) divCnt <= divCnt + 8'd1;
      else begin
        divCnt   <= '0;
        highHalf <= !highHalf;
        if (!highHalf) begin
          // Rising TCK edge: host_tdo here is the value from the preceding cycle.
          host_tck <= 1'b1;
          if (isShift) rsp_data[shiftIdx] <= host_tdo;
        end else begin
          host_tck <= 1'b0;
          tick     <= tick + 5'd1;
          if (!lastTick) {host_tms, host_tdi} <= nextBits;
        end
      end
    end
  end
endmodule

// File: tb/tb_jtag_host.sv
// tb_jtag_host: directed and randomized scans checked by a scoreboard against a tick-list model
// and a behavioural TAP target (DR captures 0x1234, IR captures 0xC3A5).
module tb_jtag_host;
  localparam int D = 4;
  localparam logic [15:0] DR_CAP = 16'h1234;
  localparam logic [15:0] IR_CAP = 16'hC3A5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid, cmd_ready, rsp_done;
  logic [1:0]  cmd_op;
  logic [3:0]  cmd_len;
  logic [15:0] cmd_data, rsp_data;
  logic        host_tck, host_tms, host_tdi;
  logic        host_tdo = 1'b0;

  jtag_host #(.CLK_DIV(D)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_len(cmd_len),
    .cmd_data(cmd_data), .rsp_done(rsp_done), .rsp_data(rsp_data),
    .host_tck(host_tck), .host_tms(host_tms), .host_tdi(host_tdi), .host_tdo(host_tdo)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag(input string name);
    tests++;
    fails++;
    $display("FAIL %s: event occurred that should not (cycle %0d)", name, cyc);
  endtask

  // ---------------- behavioural TAP target ----------------
  typedef enum int {TLR, RTI, SELDR, CAPDR, SHDR, EX1DR, PADR, EX2DR, UPDR,
                    SELIR, CAPIR, SHIR, EX1IR, PAIR, EX2IR, UPIR} tap_t;
  tap_t        tap = RTI;
  logic [15:0] dr = '0, ir = '0, drUpd, irUpd;
  logic        tapTdo;
  bit          loopMode = 1'b0;

  function automatic tap_t nextTap(input tap_t s, input logic tms);
    case (s)
      TLR:   return tms ? TLR   : RTI;
      RTI:   return tms ? SELDR : RTI;
      SELDR: return tms ? SELIR : CAPDR;
      CAPDR: return tms ? EX1DR : SHDR;
      SHDR:  return tms ? EX1DR : SHDR;
      EX1DR: return tms ? UPDR  : PADR;
      PADR:  return tms ? EX2DR : PADR;
      EX2DR: return tms ? UPDR  : SHDR;
      UPDR:  return tms ? SELDR : RTI;
      SELIR: return tms ? TLR   : CAPIR;
      CAPIR: return tms ? EX1IR : SHIR;
      SHIR:  return tms ? EX1IR : SHIR;
      EX1IR: return tms ? UPIR  : PAIR;
      PAIR:  return tms ? EX2IR : PAIR;
      EX2IR: return tms ? UPIR  : SHIR;
      UPIR:  return tms ? SELDR : RTI;
      default: return TLR;
    endcase
  endfunction

  initial forever begin
    @(posedge host_tck);
    case (tap)
      CAPDR: dr = DR_CAP;
      SHDR:  dr = {host_tdi, dr[15:1]};
      UPDR:  drUpd = dr;
      CAPIR: ir = IR_CAP;
      SHIR:  ir = {host_tdi, ir[15:1]};
      UPIR:  irUpd = ir;
      default: ;
    endcase
    tap = nextTap(tap, host_tms);
  end

  assign tapTdo = (tap == SHDR) ? dr[0] : (tap == SHIR) ? ir[0] : 1'b0;
  always @(posedge clk) host_tdo <= loopMode ? host_tdi : tapTdo;

  // ---------------- scoreboard ----------------
  typedef struct {
    int          doneCyc;
    logic [15:0] rsp;
    int          op;
    logic [15:0] upd;
  } exp_t;
  exp_t       expQ[$];
  logic [1:0] tickQ[$];
  int lastAccept = 0;
  int lastN = 0;

  task automatic pushExpect(input logic [1:0] op, input int n, input logic [15:0] d);
    exp_t        e;
    logic [31:0] mask, dm, cap;
    int          base;
    base = tickQ.size();
    mask = (32'h1 << n) - 32'h1;
    dm   = {16'h0, d} & mask;
    cap  = {16'h0, (op == 2'b01) ? IR_CAP : DR_CAP};
    if (op == 2'b00) begin
      repeat (5) tickQ.push_back(2'b10);
      tickQ.push_back(2'b00);
    end else if (op != 2'b11) begin
      if (op == 2'b01) tickQ.push_back(2'b10);
      tickQ.push_back(2'b10);
      tickQ.push_back(2'b00);
      tickQ.push_back(2'b00);
      for (int i = 0; i < n; i++) tickQ.push_back({i == n - 1, d[4'(i)]});
      tickQ.push_back(2'b10);
      tickQ.push_back(2'b00);
    end
    lastN     = tickQ.size() - base;
    e.op      = int'(op);
    e.doneCyc = (op == 2'b11) ? cyc + 1 : cyc + 2 * lastN * D;
    if (op == 2'b01 || op == 2'b10) e.rsp = loopMode ? dm[15:0] : (cap[15:0] & mask[15:0]);
    else e.rsp = 16'h0;
    e.upd = 16'((cap >> n) | (dm << (16 - n)));
    drUpd = 'x;
    irUpd = 'x;
    expQ.push_back(e);
  endtask

  initial begin
    bit         prevTck;
    bit         readyDue;
    exp_t       e;
    logic [1:0] t;
    prevTck  = 1'b0;
    readyDue = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prevTck  = 1'b0;
        readyDue = 1'b0;
      end else begin
        if (readyDue) begin
          check("ready_after_done", cmd_ready, 1);
          readyDue = 1'b0;
        end
        if (host_tck && !prevTck) begin
          if (tickQ.size() == 0) flag("extra_tck_rise");
          else begin
            t = tickQ.pop_front();
            check("tick_tms_tdi", {host_tms, host_tdi}, t);
          end
        end
        prevTck = host_tck;
        if (rsp_done) begin
          if (expQ.size() == 0) flag("unexpected_done");
          else begin
            e = expQ.pop_front();
            check("done_cycle", cyc, e.doneCyc);
            check("rsp_data", rsp_data, e.rsp);
            check("ticks_left", tickQ.size(), 0);
            check("tap_in_rti", 32'(tap), 32'(RTI));
            check("ready_low_in_done", cmd_ready, 0);
            if (e.op == 2) check("dr_shifted_in", drUpd, e.upd);
            if (e.op == 1) check("ir_shifted_in", irUpd, e.upd);
            readyDue = 1'b1;
          end
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic waitReady();
    int n = 0;
    while (!cmd_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) flag("ready_timeout");
  endtask

  task automatic present(input logic [1:0] op, input logic [3:0] l, input logic [15:0] d, input bit hold);
    cmd_op    = op;
    cmd_len   = l;
    cmd_data  = d;
    cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    lastAccept = cyc;
    pushExpect(op, int'(l) + 1, d);
    if (!hold) cmd_valid = 1'b0;
  endtask

  task automatic issue(input logic [1:0] op, input logic [3:0] l, input logic [15:0] d);
    waitReady();
    present(op, l, d, 1'b0);
  endtask

  task automatic idleCheck();
    bit seenHigh = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (host_tck) seenHigh = 1'b1;
    end
    check("tck_idle_low", seenHigh, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int n;
    cmd_valid = 1'b0;
    cmd_op    = '0;
    cmd_len   = '0;
    cmd_data  = '0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    check("rst_tck", host_tck, 0);
    check("rst_tms", host_tms, 1);
    check("rst_tdi", host_tdi, 0);
    check("rst_ready", cmd_ready, 1);
    check("rst_done", rsp_done, 0);
    check("rst_rsp", rsp_data, 0);
    idleCheck();

    // TAP reset, IR loopback, DR against the TAP model
    issue(2'b00, 4'd0, 16'h0000);
    loopMode = 1'b1;
    issue(2'b01, 4'd3, 16'h000A);
    waitReady();
    loopMode = 1'b0;
    issue(2'b10, 4'd15, 16'hBEEF);

    // busy: hold valid with changing fields; next command at 2ND+1, then reserved back-to-back
    waitReady();
    present(2'b10, 4'd7, 16'h55AA, 1'b1);
    n = 0;
    while (!cmd_ready && n < 1000) begin
      cmd_op   = 2'($urandom);
      cmd_len  = 4'($urandom);
      cmd_data = 16'($urandom);
      @(negedge clk);
      n++;
    end
    check("b2b_ready_cycle", cyc, lastAccept + 2 * lastN * D + 1);
    present(2'b11, 4'($urandom), 16'($urandom), 1'b1);
    waitReady();
    check("rsvd_ready_cycle", cyc, lastAccept + 2);
    present(2'b01, 4'd5, 16'($urandom), 1'b0);

    // reset during shift tick 5 of a 16-bit DR scan
    issue(2'b10, 4'd15, 16'($urandom));
    n = 0;
    while (cyc < lastAccept + 66 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("rsp_partial_before_rst", rsp_data, {11'h0, DR_CAP[4:0]});
    @(posedge clk);
    #2 rst = 1'b1;
    expQ.delete();
    tickQ.delete();
    #1;
    check("midrst_tck", host_tck, 0);
    check("midrst_tms", host_tms, 1);
    check("midrst_rsp", rsp_data, 0);
    check("midrst_ready", cmd_ready, 1);
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    idleCheck();
    issue(2'b00, 4'd0, 16'h0000);
    issue(2'b10, 4'd15, 16'($urandom));

    // randomized commands
    repeat (16) begin
      waitReady();
      loopMode = 1'($urandom);
      issue(2'($urandom_range(0, 3)), 4'($urandom), 16'($urandom));
    end
    waitReady();
    repeat (4) @(negedge clk);
    check("queue_drained", expQ.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
